// File: rtl/q_control_if.sv
// Lane signal bundle between the lane equipment and the barrier controller.
// master = sensors/payment terminal side, slave = controller side.
interface q_control_if;
    logic DCE;
    logic POK;
    logic PNOK;
    logic DCS;
    logic Me;
    logic Ms;
    logic Lok;
    logic Lnok;

    modport master (
        output DCE,
        output POK,
        output PNOK,
        output DCS,
        input  Me,
        input  Ms,
        input  Lok,
        input  Lnok
    );

    modport slave (
        input  DCE,
        input  POK,
        input  PNOK,
        input  DCS,
        output Me,
        output Ms,
        output Lok,
        output Lnok
    );
endinterface

// File: rtl/q_control.sv
// Boom-gate controller for a paid entry lane.
// Moore FSM: payment verdict raises the barrier, exit clearance lowers it.
module q_control #(
    parameter int RAISE_CYCLES = 2,
    parameter int LOWER_CYCLES = 2
) (
    input logic   CLK,
    input logic   RST,
    q_control_if.slave bus
);
    localparam int MAX_CYC =
        (RAISE_CYCLES > LOWER_CYCLES) ? RAISE_CYCLES : LOWER_CYCLES;
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] RAISE_LAST = CW'(RAISE_CYCLES - 1);
    localparam logic [CW-1:0] LOWER_LAST = CW'(LOWER_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PAY,
        REJECT,
        RAISING,
        OPEN,
        LOWERING
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          passed;
    logic          passed_nx;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state  <= IDLE;
            cnt    <= '0;
            passed <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            passed <= passed_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        passed_nx = passed;
        unique case (state)
            IDLE: begin
                if (bus.DCE)
                    state_nx = WAIT_PAY;
            end
            WAIT_PAY: begin
                if (!bus.DCE) begin
                    state_nx = IDLE;
                end else if (bus.PNOK) begin
                    state_nx = REJECT;
                end else if (bus.POK) begin
                    state_nx = RAISING;
                    cnt_nx   = '0;
                end
            end
            REJECT: begin
                if (bus.POK && !bus.PNOK) begin
                    state_nx = RAISING;
                    cnt_nx   = '0;
                end else if (!bus.DCE) begin
                    state_nx = IDLE;
                end
            end
            RAISING: begin
                if (bus.DCS)
                    passed_nx = 1'b1;
                if (cnt == RAISE_LAST)
                    state_nx = OPEN;
                else
                    cnt_nx = cnt + CNT_ONE;
            end
            OPEN: begin
                // leave only once the vehicle was seen and has fully cleared
                if (passed && !bus.DCS) begin
                    state_nx  = LOWERING;
                    cnt_nx    = '0;
                    passed_nx = 1'b0;
                end else if (bus.DCS) begin
                    passed_nx = 1'b1;
                end
            end
            LOWERING: begin
                if (bus.DCS) begin
                    state_nx = RAISING;
                    cnt_nx   = '0;
                end else if (cnt == LOWER_LAST) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nx  = IDLE;
                cnt_nx    = '0;
                passed_nx = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.Me   = 1'b0;
        bus.Ms   = 1'b0;
        bus.Lok  = 1'b0;
        bus.Lnok = 1'b0;
        unique case (1'b1)
            (state == REJECT):   bus.Lnok = 1'b1;
            (state == RAISING): begin
                bus.Me  = 1'b1;
                bus.Lok = 1'b1;
            end
            (state == OPEN):     bus.Lok = 1'b1;
            (state == LOWERING): bus.Ms  = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_q_control.sv
// Bench for q_control: directed vector table, hand sequences,
// then random traffic against a rule-level lane model.
module tb_q_control;
    localparam int RC = 2;
    localparam int LC = 2;

    logic CLK;
    logic RST;
    int   checks;
    int   fails;

    q_control_if bus ();

    q_control #(
        .RAISE_CYCLES(RC),
        .LOWER_CYCLES(LC)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       dce;
        logic       pok;
        logic       pnok;
        logic       dcs;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[$];

    // outputs packed as {Me, Ms, Lok, Lnok}
    function automatic logic [3:0] outs();
        return {bus.Me, bus.Ms, bus.Lok, bus.Lnok};
    endfunction

    task automatic step(input logic r, input logic e,
                        input logic ok, input logic nok,
                        input logic s);
        RST      = r;
        bus.DCE  = e;
        bus.POK  = ok;
        bus.PNOK = nok;
        bus.DCS  = s;
        @(posedge CLK);
        #1;
    endtask

    task automatic cmp(input string nm, input logic [3:0] exp);
        checks++;
        if (outs() !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (Me Ms Lok Lnok)",
                     nm, outs(), exp);
        end
    endtask

    task automatic chk(input string nm, input logic e,
                       input logic ok, input logic nok,
                       input logic s, input logic [3:0] exp);
        step(1'b1, e, ok, nok, s);
        cmp(nm, exp);
    endtask

    // reference model: lane phase plus remaining motor ticks
    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_REJ   = 2;
    localparam int P_UP    = 3;
    localparam int P_OPEN  = 4;
    localparam int P_DOWN  = 5;

    int phase;
    int ticks_left;
    bit car_seen;

    function automatic logic [3:0] phase_outs(input int p);
        case (p)
            P_REJ:   return 4'b0001;
            P_UP:    return 4'b1010;
            P_OPEN:  return 4'b0010;
            P_DOWN:  return 4'b0100;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic model(input logic r, input logic e,
                         input logic ok, input logic nok,
                         input logic s);
        if (!r) begin
            phase      = P_IDLE;
            ticks_left = 0;
            car_seen   = 0;
            return;
        end
        if (phase == P_IDLE) begin
            if (e) phase = P_WAIT;
        end else if (phase == P_WAIT) begin
            if (!e) phase = P_IDLE;
            else if (nok) phase = P_REJ;
            else if (ok) begin
                phase      = P_UP;
                ticks_left = RC;
            end
        end else if (phase == P_REJ) begin
            if (ok && !nok) begin
                phase      = P_UP;
                ticks_left = RC;
            end else if (!e) phase = P_IDLE;
        end else if (phase == P_UP) begin
            if (s) car_seen = 1;
            ticks_left--;
            if (ticks_left == 0) phase = P_OPEN;
        end else if (phase == P_OPEN) begin
            if (car_seen && !s) begin
                phase      = P_DOWN;
                ticks_left = LC;
                car_seen   = 0;
            end else if (s) car_seen = 1;
        end else begin
            if (s) begin
                phase      = P_UP;
                ticks_left = RC;
            end else begin
                ticks_left--;
                if (ticks_left == 0) phase = P_IDLE;
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        RST      = 1'b0;
        bus.DCE  = 1'b0;
        bus.POK  = 1'b0;
        bus.PNOK = 1'b0;
        bus.DCS  = 1'b0;

        // reset with busy inputs, then the happy path
        tbl.push_back('{0,1,1,0,1,4'b0000,"rst_edge1"});
        tbl.push_back('{0,1,1,1,1,4'b0000,"rst_edge2"});
        tbl.push_back('{1,0,0,0,0,4'b0000,"rst_release"});
        tbl.push_back('{1,1,0,0,0,4'b0000,"hp_wait"});
        tbl.push_back('{1,1,1,0,0,4'b1010,"hp_raise1"});
        tbl.push_back('{1,1,0,0,0,4'b1010,"hp_raise2"});
        tbl.push_back('{1,0,0,0,0,4'b0010,"hp_open"});
        tbl.push_back('{1,0,0,0,1,4'b0010,"hp_car_under"});
        tbl.push_back('{1,0,0,0,0,4'b0100,"hp_lower1"});
        tbl.push_back('{1,0,0,0,0,4'b0100,"hp_lower2"});
        tbl.push_back('{1,0,0,0,0,4'b0000,"hp_idle"});
        // reject then retry
        tbl.push_back('{1,1,0,0,0,4'b0000,"rj_wait"});
        tbl.push_back('{1,1,0,1,0,4'b0001,"rj_reject"});
        tbl.push_back('{1,1,0,0,0,4'b0001,"rj_hold"});
        tbl.push_back('{1,1,1,0,0,4'b1010,"rj_retry"});
        tbl.push_back('{1,1,0,0,0,4'b1010,"rj_raise2"});
        tbl.push_back('{1,0,0,0,0,4'b0010,"rj_open"});
        tbl.push_back('{1,0,0,0,1,4'b0010,"rj_car"});
        tbl.push_back('{1,0,0,0,0,4'b0100,"rj_lower1"});
        tbl.push_back('{1,0,0,0,0,4'b0100,"rj_lower2"});
        tbl.push_back('{1,0,0,0,0,4'b0000,"rj_idle"});
        // abort and priority
        tbl.push_back('{1,1,0,0,0,4'b0000,"ab_wait"});
        tbl.push_back('{1,0,0,0,0,4'b0000,"ab_drop"});
        tbl.push_back('{1,1,0,0,0,4'b0000,"pr_wait"});
        tbl.push_back('{1,1,1,1,0,4'b0001,"pr_both"});
        tbl.push_back('{1,0,0,0,0,4'b0000,"pr_leave"});
        tbl.push_back('{1,1,0,0,0,4'b0000,"pr_wait2"});
        tbl.push_back('{1,0,1,0,0,4'b0000,"pr_drop_pok"});
        tbl.push_back('{1,1,0,0,0,4'b0000,"pr_wait3"});
        tbl.push_back('{1,1,0,1,0,4'b0001,"pr_rej"});
        tbl.push_back('{1,1,1,1,0,4'b0001,"pr_rej_both"});
        tbl.push_back('{1,0,0,0,0,4'b0000,"pr_rej_leave"});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].dce, tbl[i].pok,
                 tbl[i].pnok, tbl[i].dcs);
            cmp(tbl[i].name, tbl[i].exp);
        end

        // car clears the exit sensor while still raising
        chk("ee_wait",   1, 0, 0, 0, 4'b0000);
        chk("ee_raise1", 1, 1, 0, 0, 4'b1010);
        chk("ee_raise2", 0, 0, 0, 1, 4'b1010);
        chk("ee_open",   0, 0, 0, 0, 4'b0010);
        chk("ee_lower1", 0, 0, 0, 0, 4'b0100);
        chk("ee_lower2", 0, 0, 0, 0, 4'b0100);
        chk("ee_idle",   0, 0, 0, 0, 4'b0000);

        // safety re-open while lowering
        chk("sf_wait",   1, 0, 0, 0, 4'b0000);
        chk("sf_raise1", 1, 1, 0, 0, 4'b1010);
        chk("sf_raise2", 0, 0, 0, 0, 4'b1010);
        chk("sf_open",   0, 0, 0, 0, 4'b0010);
        chk("sf_car",    0, 0, 0, 1, 4'b0010);
        chk("sf_lower",  0, 0, 0, 0, 4'b0100);
        chk("sf_reopen", 0, 0, 0, 1, 4'b1010);
        chk("sf_up2",    0, 0, 0, 1, 4'b1010);
        chk("sf_open2",  0, 0, 0, 0, 4'b0010);
        chk("sf_down1",  0, 0, 0, 0, 4'b0100);
        chk("sf_down2",  0, 0, 0, 0, 4'b0100);
        chk("sf_idle",   0, 0, 0, 0, 4'b0000);

        // reset wins mid-raise
        chk("mr_wait",   1, 0, 0, 0, 4'b0000);
        chk("mr_raise",  1, 1, 0, 0, 4'b1010);
        step(1'b0, 1, 1, 0, 1);
        cmp("mr_reset", 4'b0000);
        chk("mr_after",  0, 0, 0, 0, 4'b0000);

        // random traffic against the model
        model(1'b0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic r, e, ok, nok, s;
            r   = ($urandom_range(0, 99) != 0);
            e   = ($urandom_range(0, 9) < 7);
            ok  = ($urandom_range(0, 9) < 3);
            nok = ($urandom_range(0, 9) < 2);
            s   = ($urandom_range(0, 9) < 4);
            step(r, e, ok, nok, s);
            model(r, e, ok, nok, s);
            cmp($sformatf("rnd_%0d", n), phase_outs(phase));
            checks++;
            if ((bus.Me && bus.Ms) || (bus.Lok && bus.Lnok)) begin
                fails++;
                $display("FAIL rnd_inv_%0d: got %b, Me&Ms and Lok&Lnok must be 0",
                         n, outs());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
